// File: rtl/mux_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_sched_pkg : shared types and constants for the RR output mux.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mux_sched_pkg;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker : first set request at or after ptr, wrapping modulo 4.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker
  import mux_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] j;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    any = |req;
    idx = ptr;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ptr + IDXW'(k);
      if (req[j]) idx = j;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_rr_sched : manual or round-robin dwell-limited shared output mux.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [IDXW-1:0]   man_sel,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x,
  output logic [NREQ-1:0]   grant,
  output logic [IDXW-1:0]   sel,
  output logic [W-1:0]      f,
  output logic              valid
);

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [7:0]      cnt;
  logic            pick_any;
  logic [IDXW-1:0] pick_idx;

  rr_picker u_picker (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  function automatic logic [W-1:0] slice(input logic [NREQ*W-1:0] v,
                                         input logic [IDXW-1:0]   i);
    return v[int'(i)*W +: W];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      sel   <= '0;
      f     <= '0;
      grant <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        GRANT: begin
          if (cnt == 8'd0 || !req[sel]) begin
            state <= GAP;
            ptr   <= sel + 2'd1;
            grant <= '0;
            valid <= 1'b0;
          end else begin
            cnt   <= cnt - 8'd1;
            f     <= slice(x, sel);
          end
        end
        // The edge closing the single GAP cycle is the return to IDLE, so
        // the IDLE decision is taken there; this keeps the off time at one.
        default: begin
          if (!mode) begin
            state <= IDLE;
            sel   <= man_sel;
            f     <= slice(x, man_sel);
            valid <= 1'b1;
            grant <= '0;
          end else if (pick_any) begin
            state <= GRANT;
            sel   <= pick_idx;
            grant <= onehot(pick_idx);
            f     <= slice(x, pick_idx);
            valid <= 1'b1;
            cnt   <= 8'(DWELL - 1);
          end else begin
            state <= IDLE;
            valid <= 1'b0;
            grant <= '0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mux_rr_sched : vector table, corner sequences, random vs model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mux_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] man_sel = '0;
  logic [3:0] req = '0;
  logic [7:0] x = '0;

  logic [3:0] grant4, grant1;
  logic [1:0] sel4, sel1, f4, f1;
  logic       valid4, valid1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux_rr_sched #(.DWELL(4), .W(2)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .man_sel(man_sel), .req(req), .x(x),
    .grant(grant4), .sel(sel4), .f(f4), .valid(valid4)
  );

  mux_rr_sched #(.DWELL(1), .W(2)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .man_sel(man_sel), .req(req), .x(x),
    .grant(grant1), .sel(sel1), .f(f1), .valid(valid1)
  );

  // Reference: index 0 models DWELL=4, index 1 models DWELL=1.
  int         m_dwell [2];
  bit         m_busy  [2];
  int         m_owner [2];
  int         m_held  [2];
  int         m_ptr   [2];
  logic [1:0] m_sel   [2];
  logic [1:0] m_f     [2];
  logic [3:0] m_grant [2];
  logic       m_valid [2];

  function automatic logic [1:0] xs(input logic [7:0] v, input int i);
    return v[2*i +: 2];
  endfunction

  task automatic model_step(input int id);
    int pick;
    if (rst) begin
      m_busy[id] = 0; m_ptr[id] = 0; m_held[id] = 0; m_owner[id] = 0;
      m_sel[id] = 0; m_f[id] = 0; m_grant[id] = 0; m_valid[id] = 0;
    end else if (m_busy[id]) begin
      if (m_held[id] >= m_dwell[id] || !req[m_owner[id]]) begin
        m_busy[id]  = 0;
        m_grant[id] = 0;
        m_valid[id] = 0;
        m_ptr[id]   = (m_owner[id] + 1) % 4;
      end else begin
        m_held[id] = m_held[id] + 1;
        m_f[id]    = xs(x, m_owner[id]);
      end
    end else if (!mode) begin
      m_sel[id]   = man_sel;
      m_f[id]     = xs(x, int'(man_sel));
      m_valid[id] = 1;
      m_grant[id] = 0;
    end else begin
      pick = -1;
      for (int k = 0; k < 4; k++)
        if (pick < 0 && req[(m_ptr[id] + k) % 4]) pick = (m_ptr[id] + k) % 4;
      if (pick < 0) begin
        m_valid[id] = 0;
        m_grant[id] = 0;
      end else begin
        m_busy[id]  = 1;
        m_owner[id] = pick;
        m_held[id]  = 1;
        m_sel[id]   = 2'(pick);
        m_grant[id] = 4'(1 << pick);
        m_f[id]     = xs(x, pick);
        m_valid[id] = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_invariants();
    check("onehot0_d4", 32'($onehot0(grant4)), 32'd1);
    check("onehot0_d1", 32'($onehot0(grant1)), 32'd1);
    if (grant4 != 0) check("grant_sel_d4", {27'd0, valid4, grant4}, {27'd1, 4'(1 << sel4)});
    if (grant1 != 0) check("grant_sel_d1", {27'd0, valid1, grant1}, {27'd1, 4'(1 << sel1)});
  endtask

  task automatic check_model();
    check("grant_d4", 32'(grant4), 32'(m_grant[0]));
    check("sel_d4",   32'(sel4),   32'(m_sel[0]));
    check("f_d4",     32'(f4),     32'(m_f[0]));
    check("valid_d4", 32'(valid4), 32'(m_valid[0]));
    check("grant_d1", 32'(grant1), 32'(m_grant[1]));
    check("sel_d1",   32'(sel1),   32'(m_sel[1]));
    check("f_d1",     32'(f1),     32'(m_f[1]));
    check("valid_d1", 32'(valid1), 32'(m_valid[1]));
  endtask

  typedef struct {
    logic       rst;
    logic       mode;
    logic [1:0] man_sel;
    logic [3:0] req;
    logic [7:0] x;
    logic [3:0] e_grant;
    logic [1:0] e_sel;
    logic [1:0] e_f;
    logic       e_valid;
  } vec_t;

  vec_t tbl [10];

  initial begin
    m_dwell[0] = 4;
    m_dwell[1] = 1;

    //            rst  mode sel    req      x      grant    sel    f      valid
    tbl[0] = '{1'b1, 1'b0, 2'd0, 4'b0000, 8'hE4, 4'b0000, 2'd0, 2'b00, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'd2, 4'b0000, 8'hE4, 4'b0000, 2'd2, 2'b10, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 2'd3, 4'b1111, 8'hE4, 4'b0000, 2'd3, 2'b11, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0000, 2'd2, 2'b10, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0100, 2'd2, 2'b10, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 2'd0, 4'b0100, 8'hE4, 4'b0000, 2'd0, 2'b00, 1'b0};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; mode = tbl[i].mode; man_sel = tbl[i].man_sel;
      req = tbl[i].req; x = tbl[i].x;
      tick();
      check($sformatf("tbl%0d_grant", i), 32'(grant4), 32'(tbl[i].e_grant));
      check($sformatf("tbl%0d_sel", i),   32'(sel4),   32'(tbl[i].e_sel));
      check($sformatf("tbl%0d_f", i),     32'(f4),     32'(tbl[i].e_f));
      check($sformatf("tbl%0d_valid", i), 32'(valid4), 32'(tbl[i].e_valid));
    end

    // All four requesting: 0,1,2,3,0 with one gap cycle between grants.
    do_reset();
    mode = 1'b1; req = 4'b1111; x = 8'h1B;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rr_grant", 32'(grant4), 32'(1 << (g % 4)));
        check("rr_sel",   32'(sel4),   32'(g % 4));
      end
      tick();
      check("rr_gap", {28'd0, valid4, grant4[2:0]} | 32'(grant4[3]), 32'd0);
    end

    // Requester 1 drops after two grant cycles; requester 2 is next.
    do_reset();
    mode = 1'b1; req = 4'b0010;
    tick(); check("drop_c1", 32'(grant4), 32'h2);
    tick(); check("drop_c2", 32'(grant4), 32'h2);
    req = 4'b0100;
    tick(); check("drop_gap", 32'({valid4, grant4}), 32'h0);
    tick(); check("drop_next", 32'({sel4, grant4}), 32'({2'd2, 4'b0100}));

    // Reset in grant cycle 2 of requester 3 clears everything, no gap.
    do_reset();
    mode = 1'b1; req = 4'b1000; x = 8'hC0;
    tick(); tick();
    check("r3_c2", 32'(grant4), 32'h8);
    rst = 1'b1;
    tick();
    check("r3_rst", 32'({grant4, sel4, f4, valid4}), 32'h0);
    rst = 1'b0; req = 4'b1111;
    tick(); check("r3_ptr0", 32'(grant4), 32'h1);

    // Mode drops mid-grant: grant completes, gap, then manual select.
    do_reset();
    mode = 1'b1; req = 4'b0001; x = 8'hC6;
    tick();
    mode = 1'b0; man_sel = 2'd3;
    for (int c = 2; c <= 4; c++) begin
      tick(); check($sformatf("mode_c%0d", c), 32'({valid4, grant4}), 32'h11);
    end
    tick(); check("mode_gap", 32'({valid4, grant4}), 32'h0);
    tick(); check("mode_man", 32'({valid4, grant4, sel4, f4}), 32'({1'b1, 4'b0, 2'd3, 2'b11}));

    // DWELL=1: lone requester alternates one grant cycle and one gap.
    do_reset();
    mode = 1'b1; req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick(); check("dw1_pattern", 32'(grant1), (c % 2 == 0) ? 32'h1 : 32'h0);
    end

    // Randomised phase against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      mode = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) man_sel = 2'($urandom);
      if ($urandom_range(0, 3) == 0)  req = 4'($urandom);
      x = 8'($urandom);
      tick();
      check_model();
      check_invariants();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 SHALL have parameter DWELL, default 4, giving the maximum cycles per grant; legal range 1..255.
REQ-002 SHALL have parameter W, default 2, giving the width of each requester data slice.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port mode, input, 1 bit: 0 = manual select, 1 = round-robin scheduling.
REQ-006 SHALL have port man_sel, input, 2 bits: the source index used in manual mode.
REQ-007 SHALL have port req, input, 4 bits: one request line per requester.
REQ-008 SHALL have port x, input, 4*W bits: requester i data on x[W*i +: W].
REQ-009 SHALL have port grant, output, 4 bits: one-hot grant, or all zero.
REQ-010 SHALL have port sel, output, 2 bits: the registered index of the current source.
REQ-011 SHALL have port f, output, W bits: the registered shared output.
REQ-012 SHALL have port valid, output, 1 bit: f carries a current, selected value.

Function
REQ-013 SHALL implement states IDLE, GRANT and GAP, with a 2-bit round-robin pointer ptr and an 8-bit dwell counter cnt.
REQ-014 IDLE with mode=0: each cycle, sel<=man_sel, f<=x slice[man_sel], valid<=1, grant<=0; latency 1 cycle; req ignored.
REQ-015 IDLE with mode=1 and req==0: valid<=0; f and sel hold; grant=0.
REQ-016 IDLE with mode=1 and req!=0: pick the first set req[(ptr+k)%4] for k=0..3, then:
- sel<=idx, grant<=onehot(idx), f<=x slice[idx], valid<=1, cnt<=DWELL-1, go to GRANT.
REQ-017 GRANT, every cycle: f<=x slice[sel], valid=1, grant held.
REQ-018 GRANT, if cnt==0 or req[sel]==0: go to GAP and set ptr<=(sel+1)%4; otherwise cnt<=cnt-1.
REQ-019 Grant length SHALL be exactly DWELL cycles if req[sel] stays high, and the cycle req[sel] is sampled low is the last grant cycle.
REQ-020 GAP SHALL last exactly one cycle with grant=0 and valid=0, with f and sel held, then return to IDLE.
REQ-021 A mode change during GRANT or GAP SHALL take effect only on return to IDLE, and the current grant SHALL complete.
REQ-022 Pointer wrap: sel=3 completing SHALL give ptr=0.
REQ-023 A lone requester SHALL be re-granted after each GAP, giving a DWELL-on/1-off pattern.
REQ-024 Requests arriving during GRANT or GAP SHALL be arbitrated only in IDLE.
REQ-025 DWELL=1 SHALL give 1-cycle grants followed by a 1-cycle GAP.
REQ-026 grant SHALL never have more than one bit set.
REQ-027 grant!=0 SHALL imply valid=1 and grant==onehot(sel).

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, ptr=0, cnt=0, sel=2'b00, f=0, grant=4'b0000, valid=0.
REQ-029 rst SHALL override all other inputs, including mid-GRANT, with no GAP emitted.
REQ-030 After rst deasserts, the first IDLE cycle SHALL obey REQ-014..016.

Structure
REQ-031 Package mux_sched_pkg SHALL hold the state enum (IDLE, GRANT, GAP), NREQ=4 and the index width constant 2.
REQ-032 Sub-module rr_picker SHALL be combinational with inputs req[3:0] and ptr[1:0], and outputs any and idx[1:0].
REQ-033 The top level SHALL hold the FSM, counter, pointer and output registers.

Verification (DWELL=4, W=2)
REQ-034 Reset then mode=0, man_sel=2, x=8'hE4: f=2'b10 and valid=1 one cycle later, with grant=0.
REQ-035 mode=1, req=4'b1111 held: grants 0,1,2,3,0, each 4 cycles with 1 GAP cycle between, and sel follows.
REQ-036 mode=1, req=4'b0100 only: grant=4'b0100 for 4 cycles, then 1 GAP cycle, repeating; f=x[5:4].
REQ-037 req[1] granted and dropped after 2 grant cycles: GAP follows, and next idx=2 if req[2]=1.
REQ-038 rst asserted at grant cycle 2 of requester 3: next cycle all outputs at reset values and ptr=0.
REQ-039 mode 1->0 mid-GRANT: the grant completes its 4 cycles, then GAP, then manual behaviour.
